data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-requester arbiter and sequencer for the shared data memory unit. The scalar pipeline (port 0) and the vector pipeline (port 1) issue load/store requests. The arbiter grants them round-robin, drives one transaction at a time through the `mem_start`/`mem_rdy` handshake, and returns load data and completion to the granted requester. A watchdog bounds every transaction so a hung memory cannot stall both pipelines.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: maximum cycles in WAIT before the transaction is aborted with an error; must be ≥ 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  2  per-requester request; held high until `rsp_valid` for that port.
- `req_op`  in  2×2  per-requester `mem_op_t`; must be stable while `req_valid` is high.
- `req_addr`  in  2×32  per-requester base address; stable while `req_valid` is high.
- `req_data_esc`  in  2×32  scalar store data.
- `req_data_vec`  in  2×64  vector store data.
- `rsp_valid`  out  2  one-cycle completion pulse, one bit per requester.
- `rsp_err`  out  1  qualifies `rsp_valid`; 1 means the transaction timed out.
- `rsp_data_esc`  out  32  captured scalar load data; valid with `rsp_valid`.
- `rsp_data_vec`  out  64  captured vector load data; valid with `rsp_valid`.
- `busy`  out  1  high in any state other than IDLE.
- `mem_start`  out  1  one-cycle start pulse to the memory unit.
- `mem_op`  out  2  operation to the memory unit.
- `base_addr`  out  32  address to the memory unit.
- `data_in_esc`  out  32  scalar store data to the memory unit.
- `data_in_vec`  out  64  vector store data to the memory unit.
- `mem_rdy`  in  1  completion from the memory unit.
- `data_out_esc`  in  32  scalar load data from the memory unit.
- `data_out_vec`  in  64  vector load data from the memory unit.

## Operation
State machine `arb_state_t`: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - If no `req_valid` bit is set, stay in IDLE.
  - Otherwise pick the winner:
    - `prio` is the round-robin pointer, reset value 0.
    - Port `prio` wins if its `req_valid` is set; otherwise the other port wins.
  - Latch the winner's index into `grant`.
  - Latch the winner's op, address and both store-data buses into the outgoing registers.
  - Next state: ISSUE.
- **ISSUE**
  - `mem_start` = 1 for exactly this cycle.
  - Clear the timeout counter.
  - Next state: WAIT.
- **WAIT**
  - `mem_start` = 0.
  - When `mem_rdy` = 1:
    - capture `data_out_esc` and `data_out_vec` into the response registers;
    - set `rsp_err` = 0;
    - next state: RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT_CYCLES-1` with `mem_rdy` still 0:
    - set `rsp_err` = 1;
    - response data becomes 0;
    - next state: RESP.
- **RESP**
  - `rsp_valid[grant]` = 1 for this cycle only.
  - `prio` becomes `~grant` (the port just served gets lowest priority).
  - Next state: IDLE.

Outgoing registers (`mem_op`, `base_addr`, `data_in_*`):
- Held constant from ISSUE through RESP.
- Requester input changes during a transaction are ignored.

Data capture rules:
- Store operations still capture whatever appears on the load-data buses; requesters ignore the response data for stores.
- `rsp_data_*` hold their last value between responses.

Simultaneous events:
- Both requesters valid in IDLE: `prio` decides the winner.
- A new request arriving while not in IDLE waits; it is never dropped.
- `mem_rdy` seen on the same cycle the counter would expire: `mem_rdy` wins and `rsp_err` = 0.
- `mem_rdy` outside WAIT is ignored.

## Timing
- Reset values:
  - state IDLE; `prio` 0; `grant` 0;
  - `mem_start` 0, `rsp_valid` 0, `rsp_err` 0, `busy` 0;
  - `mem_op` `ST_VEC`; `base_addr`, `data_in_*`, `rsp_data_*` all 0.
- Reset mid-transaction:
  - return to IDLE next cycle with no `rsp_valid`;
  - the requester must re-issue.
- Latency: `req_valid` sampled in IDLE at cycle N:
  - `mem_start` at N+1;
  - `mem_rdy` no earlier than N+2;
  - `rsp_valid` one cycle after `mem_rdy` is sampled.
- Minimum turnaround: 4 cycles per transaction. Back-to-back requests from both ports alternate.
- All outputs are registered; no combinational path from `req_*` or `mem_*` inputs to outputs.

## Structure
- Shared package `interfaces_def_pkg` gains:
  - `mem_op_t`: `LD_VEC`=2'b10, `LD_ESC`=2'b11, `ST_VEC`=2'b00, `ST_ESC`=2'b01;
  - `arb_state_t`.
- The round-robin pick is small enough to stay inline in this module.
- One natural sub-module: `mem_timeout_counter` (clear, enable, expire flag, parameterised by `TIMEOUT_CYCLES`).

## Test plan
- **Single request:** port 0 `LD_ESC` addr 0x40; model returns 0xDEADBEEF with `mem_rdy` 3 cycles after `mem_start` → `rsp_valid` = 2'b01, `rsp_data_esc` = 0xDEADBEEF, `rsp_err` = 0.
- **Fair alternation:** both ports continuously request, port 0 `ST_ESC` 0x10 and port 1 `LD_VEC` 0x80 → grants 0,1,0,1; every `mem_start` carries the correct op and address.
- **Input freeze:** port 1 changes `req_addr` from 0x100 to 0x200 during WAIT → `base_addr` stays 0x100 until RESP.
- **Timeout:** `TIMEOUT_CYCLES` = 8, model never asserts `mem_rdy` → `rsp_valid` with `rsp_err` = 1 after 8 WAIT cycles; the next request proceeds normally.
- **Reset mid-transaction:** assert `reset` in WAIT → next cycle state is IDLE, `busy` = 0, no `rsp_valid`; a subsequent request is served with `prio` = 0.
- **Race on expiry:** `mem_rdy` on the expiry cycle → `rsp_err` = 0 and data is captured.

Source files
------------

// File: rtl/interfaces_def_pkg.sv
// ============================================================================
// Module   : interfaces_def_pkg
// Brief    : Shared memory-operation and arbiter-state types.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package interfaces_def_pkg;

    typedef enum logic [1:0] {
        ST_VEC = 2'b00,
        ST_ESC = 2'b01,
        LD_VEC = 2'b10,
        LD_ESC = 2'b11
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_timeout_counter.sv
// ============================================================================
// Module   : mem_timeout_counter
// Brief    : Watchdog counter; flags expiry after TIMEOUT_CYCLES-1 increments.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Round-robin two-port arbiter/sequencer for the shared data memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter
    import interfaces_def_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0][1:0]   req_op,
    input  logic [1:0][31:0]  req_addr,
    input  logic [1:0][31:0]  req_data_esc,
    input  logic [1:0][63:0]  req_data_vec,
    output logic [1:0]        rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_data_esc,
    output logic [63:0]       rsp_data_vec,
    output logic              busy,
    output logic              mem_start,
    output logic [1:0]        mem_op,
    output logic [31:0]       base_addr,
    output logic [31:0]       data_in_esc,
    output logic [63:0]       data_in_vec,
    input  logic              mem_rdy,
    input  logic [31:0]       data_out_esc,
    input  logic [63:0]       data_out_vec
);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        r_prio;
    logic        r_grant;
    logic        w_winner;
    logic        w_cnt_clear;
    logic        w_cnt_enable;
    logic        w_expired;

    mem_op_t     r_mem_op;
    logic [31:0] r_base_addr;
    logic [31:0] r_data_in_esc;
    logic [63:0] r_data_in_vec;
    logic [1:0]  r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_data_esc;
    logic [63:0] r_rsp_data_vec;
    logic        r_busy;
    logic        r_mem_start;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_enable),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next_state = r_state;
        w_winner     = req_valid[r_prio] ? r_prio : ~r_prio;
        w_cnt_clear  = 1'b0;
        w_cnt_enable = 1'b0;
        case (r_state)
            IDLE:  if (|req_valid) w_next_state = ISSUE;
            ISSUE: begin
                w_cnt_clear  = 1'b1;
                w_next_state = WAIT;
            end
            // A ready on the expiry cycle takes precedence over the timeout.
            WAIT: begin
                if (mem_rdy || w_expired) begin
                    w_next_state = RESP;
                end else begin
                    w_cnt_enable = 1'b1;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_prio         <= 1'b0;
            r_grant        <= 1'b0;
            r_mem_op       <= ST_VEC;
            r_base_addr    <= '0;
            r_data_in_esc  <= '0;
            r_data_in_vec  <= '0;
            r_rsp_valid    <= '0;
            r_rsp_err      <= 1'b0;
            r_rsp_data_esc <= '0;
            r_rsp_data_vec <= '0;
            r_busy         <= 1'b0;
            r_mem_start    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_mem_start <= (w_next_state == ISSUE);
            r_busy      <= (w_next_state != IDLE);
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_grant       <= w_winner;
                        r_mem_op      <= mem_op_t'(req_op[w_winner]);
                        r_base_addr   <= req_addr[w_winner];
                        r_data_in_esc <= req_data_esc[w_winner];
                        r_data_in_vec <= req_data_vec[w_winner];
                    end
                end
                WAIT: begin
                    if (mem_rdy || w_expired) begin
                        r_rsp_valid    <= r_grant ? 2'b10 : 2'b01;
                        r_rsp_err      <= ~mem_rdy;
                        r_rsp_data_esc <= mem_rdy ? data_out_esc : 32'd0;
                        r_rsp_data_vec <= mem_rdy ? data_out_vec : 64'd0;
                    end
                end
                RESP:    r_prio <= ~r_grant;
                default: ;
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_err      = r_rsp_err;
    assign rsp_data_esc = r_rsp_data_esc;
    assign rsp_data_vec = r_rsp_data_vec;
    assign busy         = r_busy;
    assign mem_start    = r_mem_start;
    assign mem_op       = r_mem_op;
    assign base_addr    = r_base_addr;
    assign data_in_esc  = r_data_in_esc;
    assign data_in_vec  = r_data_in_vec;

endmodule

`default_nettype wire
